// File: rtl/infra_pkg.sv
// Shared types for the infrastructure reset sequencer: FSM state encoding and
// a small elaboration helper used to size the shared cycle counter.
package infra_pkg;

  typedef enum logic [2:0] {
    S_MMCM_RST  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STRETCH   = 3'd2,
    S_IDELAY    = 3'd3,
    S_RELEASE   = 3'd4,
    S_RUN       = 3'd5
  } rst_state_e;

  localparam int unsigned LLC_W = 8;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/infra_sync2.sv
// Two-flop synchroniser for asynchronous level inputs (lock / ready flags).
module infra_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/infra_rst_sequencer.sv
// Board bring-up sequencer: MMCM reset/lock, settle stretch, IDELAYCTRL ready,
// then staged release of NUM_RST domain resets. Lock loss or soft_rst restarts.
module infra_rst_sequencer
  import infra_pkg::*;
#(
  parameter int unsigned NUM_RST      = 4,
  parameter int unsigned MMCM_RST_CYC = 16,
  parameter int unsigned STRETCH_CYC  = 65535,
  parameter int unsigned STAGE_GAP    = 256,
  parameter int unsigned TIMEOUT_CYC  = 1048575
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pll_lock,
  input  logic               idelay_rdy,
  input  logic               soft_rst,
  output logic               mmcm_rst,
  output logic               idelay_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               all_ready,
  output logic [LLC_W-1:0]   lock_loss_cnt,
  output logic [2:0]         state
);

  localparam int unsigned CNT_MAX = max4(MMCM_RST_CYC, STRETCH_CYC,
                                         NUM_RST * STAGE_GAP, TIMEOUT_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] MMCM_LAST    = CNT_W'(MMCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  // Timeout fires once the counter has reached TIMEOUT_CYC, i.e. a full
  // TIMEOUT_CYC cycles have elapsed with no lock/ready seen.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC);
  localparam logic [LLC_W-1:0] LLC_SAT      = '1;

  logic [1:0] async_in;
  logic [1:0] sync_out;
  logic       lock_s;
  logic       rdy_s;

  assign async_in = {idelay_rdy, pll_lock};

  infra_sync2 #(.WIDTH(1)) u_sync [1:0] (
    .gclk   (sys_clk),
    .grst_n (sys_rst_n),
    .d_i    (async_in),
    .q_o    (sync_out)
  );

  assign lock_s = sync_out[0];
  assign rdy_s  = sync_out[1];

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mmcm_rst_q, mmcm_rst_d;
  logic               idelay_rst_q, idelay_rst_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               all_ready_q, all_ready_d;
  logic [LLC_W-1:0]   llc_q, llc_d;

  // Stage i releases on the edge that completes (i+1)*STAGE_GAP cycles in S_RELEASE.
  logic [NUM_RST-1:0] stage_hit;
  for (genvar g = 0; g < NUM_RST; g++) begin : g_stage
    localparam logic [CNT_W-1:0] HIT = CNT_W'((g + 1) * STAGE_GAP - 1);
    assign stage_hit[g] = (cnt_q == HIT);
  end

  logic lock_lost;
  logic restart;

  assign lock_lost = !lock_s && (state_q inside {S_STRETCH, S_IDELAY, S_RELEASE, S_RUN});
  assign restart   = lock_lost || soft_rst;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    mmcm_rst_d   = mmcm_rst_q;
    idelay_rst_d = idelay_rst_q;
    rst_out_d    = rst_out_q;
    llc_d        = llc_q;
    all_ready_d  = 1'b0;

    case (state_q)
      S_MMCM_RST: begin
        if (cnt_q == MMCM_LAST) begin
          state_d    = S_WAIT_LOCK;
          mmcm_rst_d = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STRETCH;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = S_MMCM_RST;
          mmcm_rst_d = 1'b1;
        end
      end
      S_STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          state_d      = S_IDELAY;
          idelay_rst_d = 1'b0;
        end
      end
      S_IDELAY: begin
        if (rdy_s) begin
          state_d = S_RELEASE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = S_MMCM_RST;
          mmcm_rst_d   = 1'b1;
          idelay_rst_d = 1'b1;
        end
      end
      S_RELEASE: begin
        rst_out_d = rst_out_q & ~stage_hit;
        if (stage_hit[NUM_RST-1]) state_d = S_RUN;
      end
      S_RUN: ;
      default: state_d = S_MMCM_RST;
    endcase

    // Restart overrides any normal transition; a coincident soft_rst still
    // counts the lock loss exactly once.
    if (restart) begin
      state_d      = S_MMCM_RST;
      mmcm_rst_d   = 1'b1;
      idelay_rst_d = 1'b1;
      rst_out_d    = '1;
      if (lock_lost && llc_q != LLC_SAT) llc_d = llc_q + LLC_W'(1);
    end

    if (restart || state_d != state_q || state_q == S_RUN) cnt_d = '0;
    all_ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_MMCM_RST;
      cnt_q        <= '0;
      mmcm_rst_q   <= 1'b1;
      idelay_rst_q <= 1'b1;
      rst_out_q    <= '1;
      all_ready_q  <= 1'b0;
      llc_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mmcm_rst_q   <= mmcm_rst_d;
      idelay_rst_q <= idelay_rst_d;
      rst_out_q    <= rst_out_d;
      all_ready_q  <= all_ready_d;
      llc_q        <= llc_d;
    end
  end

  assign mmcm_rst      = mmcm_rst_q;
  assign idelay_rst    = idelay_rst_q;
  assign rst_out       = rst_out_q;
  assign all_ready     = all_ready_q;
  assign lock_loss_cnt = llc_q;
  assign state         = state_q;

endmodule

// File: tb/tb_infra_rst_sequencer.sv
// Bench for infra_rst_sequencer: directed scenarios plus random lock/ready/soft
// stimulus, all checked against a phase/elapsed-time reference model.
module tb_infra_rst_sequencer;

  localparam int NR = 3, MC = 4, SC = 8, SG = 5, TO = 20;
  localparam int P_MMCM = 0, P_WAIT = 1, P_STRETCH = 2, P_IDELAY = 3, P_RELEASE = 4, P_RUN = 5;
  localparam logic [16:0] RST_VEC = {3'd0, 1'b1, 1'b1, 3'b111, 1'b0, 8'd0};

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic pll_lock = 1'b0, idelay_rdy = 1'b0, soft_rst = 1'b0;
  logic mmcm_rst, idelay_rst, all_ready;
  logic [NR-1:0] rst_out;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;
  logic [16:0] obs;

  int checks = 0, errors = 0;
  int m_ph, m_t, m_llc;
  bit m_l1, m_l2, m_r1, m_r2;

  always #5 sys_clk = ~sys_clk;

  infra_rst_sequencer #(
    .NUM_RST(NR), .MMCM_RST_CYC(MC), .STRETCH_CYC(SC), .STAGE_GAP(SG), .TIMEOUT_CYC(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock), .idelay_rdy(idelay_rdy),
    .soft_rst(soft_rst), .mmcm_rst(mmcm_rst), .idelay_rst(idelay_rst), .rst_out(rst_out),
    .all_ready(all_ready), .lock_loss_cnt(lock_loss_cnt), .state(state)
  );

  assign obs = {state, mmcm_rst, idelay_rst, rst_out, all_ready, lock_loss_cnt};

  // Reference model: which phase we are in and how many edges since entering it.
  function automatic logic [16:0] exp_vec();
    logic [2:0] ro;
    for (int i = 0; i < NR; i++)
      ro[i] = (m_ph < P_RELEASE) || (m_ph == P_RELEASE && m_t < (i + 1) * SG);
    return {3'(m_ph), m_ph == P_MMCM, m_ph <= P_STRETCH, ro, m_ph == P_RUN, 8'(m_llc)};
  endfunction

  task automatic model_reset();
    m_ph = P_MMCM; m_t = 0; m_llc = 0;
    m_l1 = 0; m_l2 = 0; m_r1 = 0; m_r2 = 0;
  endtask

  task automatic tick();
    bit ls, rs, lost;
    int nph;
    @(posedge sys_clk);
    ls = m_l2; rs = m_r2;
    m_l2 = m_l1; m_r2 = m_r1; m_l1 = pll_lock; m_r1 = idelay_rdy;
    lost = !ls && m_ph >= P_STRETCH;
    if (lost || soft_rst) begin
      m_ph = P_MMCM; m_t = 0;
      if (lost) m_llc = (m_llc < 255) ? m_llc + 1 : 255;
    end else begin
      nph = m_ph;
      case (m_ph)
        P_MMCM:    if (m_t + 1 == MC) nph = P_WAIT;
        P_WAIT:    if (ls) nph = P_STRETCH; else if (m_t + 1 > TO) nph = P_MMCM;
        P_STRETCH: if (m_t + 1 == SC) nph = P_IDELAY;
        P_IDELAY:  if (rs) nph = P_RELEASE; else if (m_t + 1 > TO) nph = P_MMCM;
        P_RELEASE: if (m_t + 1 == NR * SG) nph = P_RUN;
        default: ;
      endcase
      m_t = (nph == m_ph) ? m_t + 1 : 0;
      m_ph = nph;
    end
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; pll_lock = 0; idelay_rdy = 0; soft_rst = 0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      pll_lock = 1'($urandom); idelay_rdy = 1'($urandom); soft_rst = 1'($urandom);
      @(negedge sys_clk);
      checks++;
      if (obs !== RST_VEC) begin
        errors++; $display("FAIL reset_hold cyc %0d: got %h want %h", c, obs, RST_VEC);
      end
    end
    pll_lock = 0; idelay_rdy = 0; soft_rst = 0;
    sys_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({state, mmcm_rst} !== {3'd0, 1'b1}) begin
        errors++; $display("FAIL reset_mmcm_hold cyc %0d: got %b want %b", c, {state, mmcm_rst}, 4'b0001);
      end
    end
    tick();
    checks++;
    if ({state, mmcm_rst} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL reset_mmcm_release: got %b want %b", {state, mmcm_rst}, 4'b0010);
    end
  endtask

  task automatic test_nominal();
    logic [2:0] seq [3];
    int si, fall_c, last_c;
    logic prev_idr;
    logic [2:0] prev_ro;
    seq[0] = 3'b110; seq[1] = 3'b100; seq[2] = 3'b000;
    do_reset();
    pll_lock = 1; idelay_rdy = 0;
    si = 0; fall_c = -1; last_c = -1; prev_idr = 1'b1; prev_ro = 3'b111;
    for (int c = 0; c < 60; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL nominal cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      if (prev_idr && !idelay_rst) fall_c = c;
      if (fall_c >= 0 && c == fall_c + 2) idelay_rdy = 1;
      if (rst_out !== prev_ro) begin
        checks++;
        if (si >= 3 || rst_out !== seq[si] || (si > 0 && c - last_c != SG)) begin
          errors++; $display("FAIL nominal_stage %0d cyc %0d: got %b gap %0d want gap %0d", si, c, rst_out, c - last_c, SG);
        end
        si++; last_c = c;
      end
      prev_idr = idelay_rst; prev_ro = rst_out;
    end
    checks++;
    if (si != 3 || all_ready !== 1'b1) begin
      errors++; $display("FAIL nominal_run: stages %0d ready %b want 3 and 1", si, all_ready);
    end
  endtask

  task automatic test_lock_timeout();
    int rises [$];
    int fall_after;
    logic prev_m;
    do_reset();
    pll_lock = 0;
    prev_m = 1'b1; fall_after = -1;
    for (int c = 0; c < 80; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL timeout cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      if (!prev_m && mmcm_rst) rises.push_back(c);
      if (prev_m && !mmcm_rst && rises.size() == 1 && fall_after < 0) fall_after = c;
      prev_m = mmcm_rst;
    end
    checks++;
    if (rises.size() != 3 || rises[1] - rises[0] != 25 || rises[2] - rises[1] != 25) begin
      errors++; $display("FAIL timeout_period: %0d rises, got spacing %0d want 25", rises.size(),
                         (rises.size() > 1) ? rises[1] - rises[0] : -1);
    end
    checks++;
    if (rises.size() < 1 || fall_after - rises[0] != MC) begin
      errors++; $display("FAIL timeout_width: got %0d want %0d", fall_after - ((rises.size() > 0) ? rises[0] : 0), MC);
    end
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL timeout_llc: got %0d want 0", lock_loss_cnt);
    end
  endtask

  task automatic test_lock_loss_run();
    bit ok;
    do_reset();
    pll_lock = 1; idelay_rdy = 1; ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL lossrun_up cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      if (all_ready === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL lossrun_reach_run: got no all_ready want 1"); end
    pll_lock = 0;
    tick(); tick();
    checks++;
    if (all_ready !== 1'b1) begin
      errors++; $display("FAIL lossrun_early: ready %b want 1", all_ready);
    end
    tick();
    checks++;
    if ({rst_out, mmcm_rst, lock_loss_cnt, state} !== {3'b111, 1'b1, 8'd1, 3'd0}) begin
      errors++; $display("FAIL lossrun_restart: got %h want %h", {rst_out, mmcm_rst, lock_loss_cnt, state},
                         {3'b111, 1'b1, 8'd1, 3'd0});
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL lossrun_model: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_soft_lockloss();
    bit ok;
    do_reset();
    pll_lock = 1; idelay_rdy = 1; ok = 0;
    for (int c = 0; c < 80 && !ok; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL soft_up cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      if (state === 3'd4) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL soft_reach_release: got state %0d want 4", state); end
    tick();
    pll_lock = 0;
    tick(); tick();
    soft_rst = 1;
    tick();
    soft_rst = 0;
    checks++;
    if ({state, rst_out, lock_loss_cnt} !== {3'd0, 3'b111, 8'd1}) begin
      errors++; $display("FAIL soft_combined: got %h want %h", {state, rst_out, lock_loss_cnt}, {3'd0, 3'b111, 8'd1});
    end
    pll_lock = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL soft_after cyc %0d: got %h want %h", c, obs, exp_vec());
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd1) begin
      errors++; $display("FAIL soft_single_count: got %0d want 1", lock_loss_cnt);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    for (int ev = 0; ev < 260; ev++) begin
      pll_lock = 1; ok = 0;
      for (int c = 0; c < 40 && !ok; c++) begin
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          errors++; $display("FAIL sat ev %0d cyc %0d: got %h want %h", ev, c, obs, exp_vec());
        end
        if (state === 3'd2) ok = 1;
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL sat_reach_stretch ev %0d: got state %0d want 2", ev, state);
      end
      pll_lock = 0;
      repeat (3) begin
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          errors++; $display("FAIL sat_drop ev %0d: got %h want %h", ev, obs, exp_vec());
        end
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_final: got %0d want 255", lock_loss_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    pll_lock = 1; idelay_rdy = 1; ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      tick();
      if (state === 3'd4) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL async_reach_release: got state %0d want 4", state); end
    repeat (3) tick();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL async_pre: got %h want %h", obs, exp_vec());
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL async_immediate: got %h want %h", obs, RST_VEC);
    end
    model_reset();
    @(negedge sys_clk);
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL async_held: got %h want %h", obs, RST_VEC);
    end
    sys_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL async_after cyc %0d: got %h want %h", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      pll_lock   = ($urandom_range(0, 99) != 0);
      idelay_rdy = ($urandom_range(0, 3) != 0);
      soft_rst   = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", c, obs, exp_vec());
      end
    end
    soft_rst = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_timeout();
    test_lock_loss_run();
    test_soft_lockloss();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
